// File: rtl/ureg_fifo.sv
// ureg_fifo: 256x16 show-ahead FIFO for the user-register bus.
// The head word is held in a register so q is always valid while non-empty.
// Writing into an empty FIFO bypasses the array straight into that register.
module ureg_fifo #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 wr_req,
    input  logic                 rd_req,
    input  logic                 sclr,
    output logic [WIDTH-1:0]     q,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   usedw,
    output logic [15:0]          status
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] ONE_CNT  = (ADDR_BITS + 1)'(1);

    logic [WIDTH-1:0]     mem [DEPTH];

    logic [ADDR_BITS-1:0] wp_q, wp_d;
    logic [ADDR_BITS-1:0] rp_q, rp_d;
    logic [ADDR_BITS:0]   usedw_q, usedw_d;
    logic [WIDTH-1:0]     head_q, head_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;

    logic                 empty_w;
    logic                 full_w;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] rp_next;

    // Flags come only from the registered count, never from the strobes.
    always_comb begin
        empty_w = (usedw_q == '0);
        full_w  = (usedw_q == FULL_CNT);
    end

    // Accept/reject decisions, pointer and count updates, and head-word selection.
    always_comb begin
        pop_ok  = rd_req && !empty_w;
        // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
        push_ok = wr_req && (!full_w || pop_ok);
        rp_next = rp_q + ADDR_BITS'(1);

        wp_d    = wp_q;
        rp_d    = rp_q;
        usedw_d = usedw_q;
        head_d  = head_q;
        ovf_d   = ovf_q | (wr_req && !push_ok);
        udf_d   = udf_q | (rd_req && !pop_ok);
        mem_we  = 1'b0;

        if (sclr) begin
            wp_d    = '0;
            rp_d    = '0;
            usedw_d = '0;
            head_d  = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            mem_we = push_ok;
            if (push_ok) wp_d = wp_q + ADDR_BITS'(1);
            if (pop_ok)  rp_d = rp_next;

            if (push_ok && !pop_ok)      usedw_d = usedw_q + ONE_CNT;
            else if (pop_ok && !push_ok) usedw_d = usedw_q - ONE_CNT;

            if (pop_ok) begin
                // Popping the last word: the new head is the word being pushed now,
                // otherwise q keeps its last value with empty raised.
                if (usedw_q == ONE_CNT) begin
                    if (push_ok) head_d = data_in;
                end else begin
                    head_d = mem[rp_next];
                end
            end else if (push_ok && empty_w) begin
                head_d = data_in;
            end
        end
    end

    // Storage array; no reset needed since the head register masks stale contents.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wp_q] <= data_in;
    end

    // Control and head-word registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            usedw_q <= '0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            usedw_q <= usedw_d;
            head_q  <= head_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign q      = head_q;
    assign empty  = empty_w;
    assign full   = full_w;
    assign usedw  = usedw_q;
    assign status = {full_w, empty_w, ovf_q, udf_q, 12'(usedw_q)};

endmodule
